// File: rtl/reaction_timer.sv
// Reaction timer: arms with the starting line, counts i_tick from go to button press, flags false starts, keeps best time.
// Press is seen 3 edges after the raw button rises; results and flags are registered outputs with no backpressure.
module reaction_timer #(
  parameter int MAX_COUNT = 9999,
  parameter int COUNT_W   = 14
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_arm,
  input  logic               i_go,
  input  logic               i_button,
  input  logic               i_clear,
  output logic               o_busy,
  output logic               o_valid,
  output logic               o_falseStart,
  output logic               o_timeout,
  output logic [COUNT_W-1:0] o_reactionMs,
  output logic [COUNT_W-1:0] o_bestMs
);

  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_TIMING = 3'd2,
    S_RESULT = 3'd3,
    S_FOUL   = 3'd4
  } state_t;

  state_t             state;
  logic [COUNT_W-1:0] count;
  logic               b1, b2, b3;
  logic               press;

  // b1 is the metastability flop; b2/b3 form the rising-edge detector.
  assign press = b2 & ~b3;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      count        <= '0;
      b1           <= 1'b0;
      b2           <= 1'b0;
      b3           <= 1'b0;
      o_busy       <= 1'b0;
      o_valid      <= 1'b0;
      o_falseStart <= 1'b0;
      o_timeout    <= 1'b0;
      o_reactionMs <= '0;
      o_bestMs     <= MAX_C;
    end else begin
      b1      <= i_button;
      b2      <= b1;
      b3      <= b2;
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_arm) begin
            state        <= S_ARMED;
            o_busy       <= 1'b1;
            o_falseStart <= 1'b0;
            o_timeout    <= 1'b0;
          end
        end
        S_ARMED: begin
          if (press) begin
            state        <= S_FOUL;
            o_busy       <= 1'b0;
            o_valid      <= 1'b1;
            o_falseStart <= 1'b1;
          end else if (i_go) begin
            state <= S_TIMING;
            count <= '0;
          end else if (!i_arm) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        S_TIMING: begin
          // A press wins over both the tick and the timeout, latching the pre-increment count.
          if (press) begin
            state        <= S_RESULT;
            o_busy       <= 1'b0;
            o_valid      <= 1'b1;
            o_reactionMs <= count;
            if (count < o_bestMs) o_bestMs <= count;
          end else if (count == MAX_C) begin
            state        <= S_RESULT;
            o_busy       <= 1'b0;
            o_valid      <= 1'b1;
            o_timeout    <= 1'b1;
            o_reactionMs <= MAX_C;
          end else if (i_tick) begin
            count <= count + 1'b1;
          end
        end
        S_RESULT, S_FOUL: begin
          if (i_clear) state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: a default instance for normal play and a MAX_COUNT=20 instance for timeout.
module tb_reaction_timer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_tick = 1'b0;
  logic        i_arm = 1'b0;
  logic        i_go = 1'b0;
  logic        i_button = 1'b0;
  logic        i_clear = 1'b0;

  logic        busy, valid, fs, to;
  logic [13:0] react, best;
  logic        s_busy, s_valid, s_fs, s_to;
  logic [13:0] s_react, s_best;

  int checks = 0;
  int failures = 0;
  logic found;

  reaction_timer u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_arm(i_arm), .i_go(i_go),
    .i_button(i_button), .i_clear(i_clear), .o_busy(busy), .o_valid(valid),
    .o_falseStart(fs), .o_timeout(to), .o_reactionMs(react), .o_bestMs(best)
  );

  reaction_timer #(.MAX_COUNT(20), .COUNT_W(14)) u_short (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_arm(i_arm), .i_go(i_go),
    .i_button(i_button), .i_clear(i_clear), .o_busy(s_busy), .o_valid(s_valid),
    .o_falseStart(s_fs), .o_timeout(s_to), .o_reactionMs(s_react), .o_bestMs(s_best)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_go();
    i_go = 1'b1; cyc(1); i_go = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      i_tick = 1'b1; cyc(1); i_tick = 1'b0; cyc(1);
    end
  endtask

  task automatic clear_pulse();
    i_clear = 1'b1; cyc(1); i_clear = 1'b0; cyc(1);
  endtask

  // Raise the button and wait (bounded) for the default instance's o_valid pulse.
  task automatic press_wait(input string tag);
    i_button = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc(1);
      if (valid) found = 1'b1;
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic attempt(input int n, input string tag);
    i_arm = 1'b1; cyc(2);
    pulse_go();
    ticks(n);
    press_wait(tag);
  endtask

  task automatic finish_attempt();
    i_button = 1'b0; i_arm = 1'b0; cyc(4);
    clear_pulse();
  endtask

  initial begin
    // Reset state
    i_rst = 1'b1; cyc(3); i_rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_fs", {31'd0, fs}, 32'd0);
    chk("rst_to", {31'd0, to}, 32'd0);
    chk("rst_react", react, 32'd0);
    chk("rst_best", best, 32'd9999);

    // Normal reaction 250
    attempt(250, "n250_valid");
    chk("n250_react", react, 32'd250);
    chk("n250_best", best, 32'd250);
    chk("n250_fs", {31'd0, fs}, 32'd0);
    chk("n250_to", {31'd0, to}, 32'd0);
    chk("n250_busy", {31'd0, busy}, 32'd0);
    cyc(1);
    chk("n250_valid_1cyc", {31'd0, valid}, 32'd0);
    finish_attempt();

    // Better time 180, then a worse 300
    attempt(180, "n180_valid");
    chk("n180_react", react, 32'd180);
    chk("n180_best", best, 32'd180);
    finish_attempt();
    attempt(300, "n300_valid");
    chk("n300_react", react, 32'd300);
    chk("n300_best", best, 32'd180);
    finish_attempt();

    // False start before go
    i_arm = 1'b1; cyc(3);
    chk("fs_busy_armed", {31'd0, busy}, 32'd1);
    press_wait("fs_valid");
    chk("fs_flag", {31'd0, fs}, 32'd1);
    chk("fs_react_hold", react, 32'd300);
    chk("fs_best_hold", best, 32'd180);
    cyc(1);
    pulse_go(); cyc(3);
    chk("fs_go_ignored_busy", {31'd0, busy}, 32'd0);
    chk("fs_go_ignored_valid", {31'd0, valid}, 32'd0);
    chk("fs_go_ignored_flag", {31'd0, fs}, 32'd1);
    finish_attempt();

    // Press edge coincident with go -> FOUL
    i_arm = 1'b1; cyc(3);
    chk("fs_cleared_on_arm", {31'd0, fs}, 32'd0);
    i_button = 1'b1; cyc(2);
    i_go = 1'b1; cyc(1); i_go = 1'b0;
    chk("go_press_valid", {31'd0, valid}, 32'd1);
    chk("go_press_fs", {31'd0, fs}, 32'd1);
    chk("go_press_busy", {31'd0, busy}, 32'd0);
    finish_attempt();

    // Press coincident with the 37th tick -> pre-increment count 36
    i_arm = 1'b1; cyc(2);
    pulse_go();
    ticks(36);
    i_button = 1'b1; cyc(2);
    i_tick = 1'b1; cyc(1); i_tick = 1'b0;
    chk("tick_press_valid", {31'd0, valid}, 32'd1);
    chk("tick_press_react", react, 32'd36);
    chk("tick_press_best", best, 32'd36);
    finish_attempt();

    // Held button through arm and go, released, pressed again after 90 ticks
    i_button = 1'b1; cyc(6);
    i_arm = 1'b1; cyc(2);
    pulse_go();
    ticks(45);
    chk("held_no_foul", {31'd0, fs}, 32'd0);
    chk("held_busy", {31'd0, busy}, 32'd1);
    i_button = 1'b0;
    ticks(45);
    press_wait("held_valid");
    chk("held_react", react, 32'd90);
    chk("held_fs", {31'd0, fs}, 32'd0);
    chk("held_best", best, 32'd36);
    finish_attempt();

    // Arm dropped without go -> IDLE, no valid
    i_arm = 1'b1; cyc(3);
    chk("armdrop_busy_hi", {31'd0, busy}, 32'd1);
    i_arm = 1'b0; cyc(1);
    chk("armdrop_busy_lo", {31'd0, busy}, 32'd0);
    chk("armdrop_valid", {31'd0, valid}, 32'd0);
    cyc(2);
    chk("armdrop_valid_late", {31'd0, valid}, 32'd0);

    // Reset mid-TIMING at count 55
    i_arm = 1'b1; cyc(2);
    pulse_go();
    ticks(55);
    i_rst = 1'b1; cyc(1); i_rst = 1'b0; i_arm = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_fs", {31'd0, fs}, 32'd0);
    chk("midrst_to", {31'd0, to}, 32'd0);
    chk("midrst_react", react, 32'd0);
    chk("midrst_best", best, 32'd9999);
    cyc(2);

    // Timeout on the MAX_COUNT=20 instance
    i_arm = 1'b1; cyc(2);
    pulse_go();
    ticks(19);
    chk("to_pre_valid", {31'd0, s_valid}, 32'd0);
    chk("to_pre_busy", {31'd0, s_busy}, 32'd1);
    i_tick = 1'b1; cyc(1); i_tick = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      cyc(1);
      if (s_valid) found = 1'b1;
    end
    chk("to_valid", {31'd0, found}, 32'd1);
    chk("to_flag", {31'd0, s_to}, 32'd1);
    chk("to_react", s_react, 32'd20);
    chk("to_best", s_best, 32'd20);
    chk("to_fs", {31'd0, s_fs}, 32'd0);
    chk("to_busy", {31'd0, s_busy}, 32'd0);
    i_arm = 1'b0;

    // Clear together with reset: reset wins
    i_clear = 1'b1; i_rst = 1'b1; cyc(1); i_clear = 1'b0; i_rst = 1'b0;
    chk("clr_rst_to", {31'd0, s_to}, 32'd0);
    chk("clr_rst_react", s_react, 32'd0);
    chk("clr_rst_best", best, 32'd9999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
